// File: rtl/mem_access_unit.sv
// Load/store initiator between the MEM stage and a synchronous word-wide data
// memory. Converts byte-addressed requests into single-cycle word read/write
// strobes, does read-modify-write for sub-word stores, and extends sub-word
// load data. Misaligned or out-of-range requests are answered with an error
// and never touch the memory.
module mem_access_unit #(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_error,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_write_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [31:0]       mem_read_data
);

    typedef enum logic [2:0] {
        IDLE,
        LD_ISSUE,
        LD_WAIT,
        ST_ISSUE,
        RMW_ISSUE,
        RMW_WAIT,
        RMW_WRITE
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    state_t state, state_n;

    // Request fields captured at acceptance; the request bus is free afterwards
    logic [1:0]  lane_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] wdata_q;

    // Next values of the registered outputs
    logic              resp_valid_n;
    logic [31:0]       resp_rdata_n;
    logic              resp_error_n;
    logic [ADDR_W-1:0] mem_address_n;
    logic [31:0]       mem_write_data_n;
    logic              mem_write_n;
    logic              mem_read_n;

    logic accept;
    logic req_bad;

    // Select the addressed byte or halfword and sign- or zero-extend it
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [1:0]  size,
                                                 input logic        uns);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed byte or halfword of the old word with store data
    function automatic logic [31:0] merge_store(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  lane,
                                                input logic [1:0]  size);
        logic [31:0] r;
        r = word;
        if (size == SZ_BYTE) begin
            r[{lane, 3'b000} +: 8] = wdata[7:0];
        end else begin
            r[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        end
        return r;
    endfunction

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    assign req_bad = (req_size == SZ_RSVD)
                   || ((req_size == SZ_HALF) && req_addr[0])
                   || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                   || (req_addr[31:ADDR_W+2] != '0);

    // Next-state and next-output decode; strobes and response default to idle
    always_comb begin
        state_n          = state;
        resp_valid_n     = 1'b0;
        resp_error_n     = 1'b0;
        resp_rdata_n     = resp_rdata;
        mem_address_n    = mem_address;
        mem_write_data_n = mem_write_data;
        mem_write_n      = 1'b0;
        mem_read_n       = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_bad) begin
                        resp_valid_n = 1'b1;
                        resp_error_n = 1'b1;
                        resp_rdata_n = 32'd0;
                    end else begin
                        mem_address_n = req_addr[ADDR_W+1:2];
                        if (!req_we) begin
                            state_n    = LD_ISSUE;
                            mem_read_n = 1'b1;
                        end else if (req_size == SZ_WORD) begin
                            state_n          = ST_ISSUE;
                            mem_write_n      = 1'b1;
                            mem_write_data_n = req_wdata;
                        end else begin
                            state_n    = RMW_ISSUE;
                            mem_read_n = 1'b1;
                        end
                    end
                end
            end
            LD_ISSUE: state_n = LD_WAIT;
            LD_WAIT: begin
                state_n      = IDLE;
                resp_valid_n = 1'b1;
                resp_rdata_n = extract_load(mem_read_data, lane_q, size_q, uns_q);
            end
            ST_ISSUE: begin
                state_n      = IDLE;
                resp_valid_n = 1'b1;
                resp_rdata_n = 32'd0;
            end
            RMW_ISSUE: state_n = RMW_WAIT;
            RMW_WAIT: begin
                state_n          = RMW_WRITE;
                mem_write_n      = 1'b1;
                mem_write_data_n = merge_store(mem_read_data, wdata_q, lane_q, size_q);
            end
            RMW_WRITE: begin
                state_n      = IDLE;
                resp_valid_n = 1'b1;
                resp_rdata_n = 32'd0;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            resp_valid     <= 1'b0;
            resp_error     <= 1'b0;
            resp_rdata     <= 32'd0;
            mem_address    <= '0;
            mem_write_data <= 32'd0;
            mem_write      <= 1'b0;
            mem_read       <= 1'b0;
        end else begin
            state          <= state_n;
            resp_valid     <= resp_valid_n;
            resp_error     <= resp_error_n;
            resp_rdata     <= resp_rdata_n;
            mem_address    <= mem_address_n;
            mem_write_data <= mem_write_data_n;
            mem_write      <= mem_write_n;
            mem_read       <= mem_read_n;
        end
    end

    // Capture request fields at acceptance (datapath only, no reset needed)
    always_ff @(posedge clk) begin
        if (accept && !reset) begin
            lane_q  <= req_addr[1:0];
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            wdata_q <= req_wdata;
        end
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator between the MEM pipeline stage and the 128-word synchronous data memory. It accepts one byte-addressed load or store at a time and converts it into word-addressed `mem_read`/`mem_write` pulses. It handles the memory's one-cycle read latency, performs read-modify-write for byte and halfword stores, and extracts and sign- or zero-extends sub-word load data. Misaligned and out-of-range requests are rejected without any memory access.

## Interface
- `ADDR_W`, 7, word-address width of the data memory (2^ADDR_W words of 32 bits)
- `clk` in 1: single clock, all state updates on rising edge
- `reset` in 1: synchronous, active-high
- `req_valid` in 1: request present
- `req_ready` out 1: `state==IDLE`; a request is accepted on an edge where `req_valid && req_ready && !reset`
- `req_we` in 1: 1 = store, 0 = load
- `req_size` in 2: 00 byte, 01 halfword, 10 word, 11 reserved
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend
- `req_addr` in 32: byte address
- `req_wdata` in 32: store data, taken from the low bits for byte/halfword
- `resp_valid` out 1: one-cycle completion pulse
- `resp_rdata` out 32: load result; 0 for stores and errors; held until the next response
- `resp_error` out 1: pulses with `resp_valid` on a rejected request
- `mem_address` out ADDR_W: word address = `req_addr[ADDR_W+1:2]`
- `mem_write_data` out 32: word written to memory
- `mem_write` out 1: memory write strobe
- `mem_read` out 1: memory read strobe
- `mem_read_data` in 32: memory output, valid the cycle after `mem_read` is sampled

## Operation
- All outputs except `req_ready` are registered. Reset value of every registered output is 0. State resets to IDLE.
- Byte lanes are little-endian: lane k is `[8k+7:8k]` and is selected by `addr[1:0]`. A halfword uses lanes {addr[1]*2+1, addr[1]*2}.
- Error check at acceptance. Any of these rejects the request:
  - `req_size==11`
  - halfword with `addr[0]`=1
  - word with `addr[1:0]`≠0
  - `req_addr[31:ADDR_W+2]`≠0
- Rejected request: next edge sets `resp_valid`=1, `resp_error`=1, `resp_rdata`=0, stays in IDLE. No strobe is ever asserted.
- Request fields (lane, size, unsigned, wdata) are captured at acceptance. Later changes on `req_*` are ignored.
- FSM states: IDLE, LD_ISSUE, LD_WAIT, ST_ISSUE, RMW_ISSUE, RMW_WAIT, RMW_WRITE.
  - Load: IDLE → LD_ISSUE (`mem_read`=1) → LD_WAIT (`mem_read`=0) → IDLE. On the last transition, capture the extracted and extended lane(s) of `mem_read_data` into `resp_rdata` and pulse `resp_valid`.
  - Word store: IDLE → ST_ISSUE (`mem_write`=1, `mem_write_data`=wdata) → IDLE. On the return to IDLE, `mem_write`=0 and `resp_valid` pulses.
  - Sub-word store:
    - IDLE → RMW_ISSUE (`mem_read`=1) → RMW_WAIT (`mem_read`=0).
    - RMW_WAIT → RMW_WRITE: `mem_write`=1 and `mem_write_data` = `mem_read_data` with the selected lane(s) replaced by `wdata[7:0]` or `wdata[15:0]`.
    - RMW_WRITE → IDLE with `resp_valid` pulse.
- `mem_read` and `mem_write` are never 1 in the same cycle. Each strobe is high for exactly one cycle per access.

## Timing
- Acceptance edge = E0. Response pulse `resp_valid` timing:
  - Error: in the cycle after E0.
  - Word store: 2 cycles after E0.
  - Load: 3 cycles after E0.
  - Sub-word store: 4 cycles after E0.
- Back-to-back: `req_ready` is 1 in the same cycle as `resp_valid`, so the next request can be accepted then. Throughput is one load per 3 cycles.
- `req_ready` is 0 in every non-IDLE state. Requests presented while `reset`=1 are not accepted.
- Reset mid-operation:
  - Next edge returns to IDLE and clears all outputs. No `resp_valid` is produced for the abandoned request.
  - A strobe already high in the reset cycle is still sampled by memory at that edge. A write in ST_ISSUE/RMW_WRITE therefore completes; a reset in RMW_ISSUE/RMW_WAIT produces no write.

## Test plan
- Word store 0xDEADBEEF to 0x34 → `mem_write`=1 with `mem_address`=13 one cycle after E0, `resp_valid` at E0+2. Load word 0x34 → `resp_rdata`=0xDEADBEEF at E0+3, `resp_error`=0.
- Word 13 = 0x11223344, byte store 0xAA to 0x35 → `mem_read` at E0+1, `mem_write` at E0+3 with data 0x1122AA44, `resp_valid` at E0+4. A reload returns 0x1122AA44.
- Word 16 = 0x80FF7F01 → responses:
  - lb 0x42 → 0xFFFFFFFF
  - lbu 0x42 → 0x000000FF
  - lh 0x42 → 0xFFFF80FF
  - lhu 0x40 → 0x00007F01
  - lb 0x43 → 0xFFFFFF80
- Each of the following gives `resp_error`=1, `resp_rdata`=0 at E0+1, and no `mem_read`/`mem_write` at any time: lw 0x36, lh 0x41, lw 0x200, `req_size`=11.
- Sub-word store accepted, `reset` high during RMW_WAIT → no `mem_write` ever, all outputs 0 next cycle, `req_ready`=1 once reset drops, memory word unchanged.
- `req_valid` held high with loads to 0x34 then 0x40 → second load is accepted in the same cycle as the first `resp_valid`, and its response follows 3 cycles later.
